// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file widths, index type and write-back requester ids
package rf_pkg;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NREG = 1 << AW;
  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;
  typedef logic [AW-1:0] reg_idx_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant starting at a pointer that moves past the winner on advance
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr_q, ptr_d;
  // scan downward so the requester closest to the pointer is assigned last and wins
  always_comb begin
    int idx;
    logic [PW-1:0] nxt;
    grant = '0;
    nxt = ptr_q;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % N;
      if (req[idx]) begin
        grant = '0;
        grant[idx] = 1'b1;
        nxt = PW'((idx + 1) % N);
      end
    end
    ptr_d = advance ? nxt : ptr_q;
  end
  // pointer register
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/rf_wb_sched.sv
// rf_wb_sched: write-back port sharing, busy-bit scoreboard and issue hazard stall
module rf_wb_sched
  import rf_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_iss_valid,
  input  logic [AW-1:0]     i_iss_rs1,
  input  logic [AW-1:0]     i_iss_rs2,
  input  logic [AW-1:0]     i_iss_rd,
  input  logic              i_iss_we,
  output logic              o_iss_stall,
  input  logic [NREQ-1:0]   i_wb_valid,
  input  logic [NREQ*AW-1:0] i_wb_addr,
  input  logic [NREQ*DW-1:0] i_wb_data,
  output logic [NREQ-1:0]   o_wb_ready,
  output logic              o_rf_wr_en,
  output logic [AW-1:0]     o_rf_wr_addr,
  output logic [DW-1:0]     o_rf_wr_data,
  output logic              o_sb_err
);
  logic [NREG-1:0] busy_q, busy_d;
  logic            wr_en_q, wr_en_d, sb_err_q, sb_err_d;
  reg_idx_t        wr_addr_q, wr_addr_d, wb_addr;
  logic [DW-1:0]   wr_data_q, wr_data_d, wb_data;
  logic [NREQ-1:0] grant;
  logic            hs, accept;
  rr_arbiter #(.N(NREQ)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (i_wb_valid),
    .advance(hs),
    .grant  (grant)
  );
  // handshake, stall and the granted requester's address/data
  always_comb begin
    o_wb_ready = rst ? '0 : grant;
    hs = |(i_wb_valid & o_wb_ready);
    o_iss_stall = rst | (i_iss_valid & (busy_q[i_iss_rs1] | busy_q[i_iss_rs2] | (i_iss_we & busy_q[i_iss_rd])));
    accept = i_iss_valid & ~o_iss_stall & i_iss_we & (i_iss_rd != '0);
    wb_addr = '0;
    wb_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (o_wb_ready[k]) begin
        wb_addr = i_wb_addr[k*AW +: AW];
        wb_data = i_wb_data[k*DW +: DW];
      end
    end
  end
  // next state: clear on commit, then set on issue so a same-edge set wins
  always_comb begin
    busy_d = busy_q;
    if (o_rf_wr_en) busy_d[o_rf_wr_addr] = 1'b0;
    if (accept) busy_d[i_iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
    wr_en_d = hs & (wb_addr != '0);
    wr_addr_d = hs ? wb_addr : wr_addr_q;
    wr_data_d = hs ? wb_data : wr_data_q;
    sb_err_d = sb_err_q | (hs & (wb_addr != '0) & ~busy_q[wb_addr]);
  end
  // scoreboard and write-port register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      sb_err_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      sb_err_q <= sb_err_d;
    end
  end
  // a write registered just before reset must not reach the RF while reset is high
  assign o_rf_wr_en = wr_en_q & ~rst;
  assign o_rf_wr_addr = wr_addr_q;
  assign o_rf_wr_data = wr_data_q;
  assign o_sb_err = sb_err_q;
endmodule

// File: tb/tb_rf_wb_sched.sv
// tb_rf_wb_sched: directed table-driven and sequence checks for the write-back scheduler
module tb_rf_wb_sched;
  import rf_pkg::*;
  logic clk = 0, rst = 1;
  logic iss_valid = 0, iss_we = 0;
  logic [AW-1:0] rs1 = 0, rs2 = 0, rd = 0;
  logic stall;
  logic [1:0] wb_valid = 0, wb_ready;
  logic [2*AW-1:0] wb_addr = 0;
  logic [2*DW-1:0] wb_data = 0;
  logic wr_en, sb_err;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  int total = 0, bad = 0;

  rf_wb_sched dut (
    .clk(clk), .rst(rst),
    .i_iss_valid(iss_valid), .i_iss_rs1(rs1), .i_iss_rs2(rs2), .i_iss_rd(rd), .i_iss_we(iss_we),
    .o_iss_stall(stall),
    .i_wb_valid(wb_valid), .i_wb_addr(wb_addr), .i_wb_data(wb_data), .o_wb_ready(wb_ready),
    .o_rf_wr_en(wr_en), .o_rf_wr_addr(wr_addr), .o_rf_wr_data(wr_data), .o_sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic v; logic [4:0] r1, r2, d; logic we; logic exp; } stall_vec_t;
  typedef struct { logic [4:0] a_alu, a_lsu; logic [1:0] exp_rdy; logic [4:0] exp_addr; } arb_vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] d);
    iss_valid = 1; iss_we = 1; rs1 = 0; rs2 = 0; rd = d;
    #1;
    chk("issue_nostall", stall, 0);
    step();
    iss_valid = 0; iss_we = 0; rd = 0;
  endtask

  stall_vec_t sv[7];
  arb_vec_t av[4];

  initial begin
    sv[0] = '{1, 5, 0, 0, 0, 1};
    sv[1] = '{1, 0, 5, 0, 0, 1};
    sv[2] = '{1, 0, 0, 5, 1, 1};
    sv[3] = '{1, 0, 0, 5, 0, 0};
    sv[4] = '{0, 5, 5, 5, 1, 0};
    sv[5] = '{1, 3, 4, 6, 1, 0};
    sv[6] = '{1, 0, 0, 0, 1, 0};
    av[0] = '{10, 11, 2'b01, 10};
    av[1] = '{12, 11, 2'b10, 11};
    av[2] = '{12, 13, 2'b01, 12};
    av[3] = '{14, 13, 2'b10, 13};

    // 1: reset with all requesters valid
    wb_valid = 2'b11;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rst_ready", wb_ready, 0);
      chk("rst_stall", stall, 1);
      chk("rst_wr_en", wr_en, 0);
      step();
    end
    rst = 0; wb_valid = 0;
    iss_valid = 1; rs1 = 5; rs2 = 9; rd = 31; iss_we = 1;
    #1;
    chk("post_rst_nobusy", stall, 0);
    chk("post_rst_addr", wr_addr, 0);
    chk("post_rst_data", wr_data, 0);
    chk("post_rst_err", sb_err, 0);
    iss_valid = 0; iss_we = 0;

    // 2: RAW hazard on r5, cleared by an ALU write-back
    issue(5);
    foreach (sv[i]) begin
      iss_valid = sv[i].v; rs1 = sv[i].r1; rs2 = sv[i].r2; rd = sv[i].d; iss_we = sv[i].we;
      #1;
      chk($sformatf("stall_vec%0d", i), stall, sv[i].exp);
    end
    iss_valid = 1; iss_we = 0; rs1 = 5; rs2 = 0; rd = 0;
    wb_valid = 2'b01; wb_addr = {5'd0, 5'd5}; wb_data = {32'h0, 32'hDEADBEEF};
    #1;
    chk("alu_ready", wb_ready, 2'b01);
    step();
    wb_valid = 0;
    #1;
    chk("alu_wr_en", wr_en, 1);
    chk("alu_wr_addr", wr_addr, 5);
    chk("alu_wr_data", wr_data, 32'hDEADBEEF);
    chk("stall_until_commit", stall, 1);
    step();
    chk("stall_released", stall, 0);
    chk("wr_en_drop", wr_en, 0);
    iss_valid = 0;

    // 4: rd=0 never goes busy; write-back to x0 is accepted but not written
    issue(0);
    iss_valid = 1; rs1 = 0; rs2 = 0; rd = 0; iss_we = 1;
    #1;
    chk("x0_nostall", stall, 0);
    iss_valid = 0; iss_we = 0;
    wb_valid = 2'b10; wb_addr = {5'd0, 5'd0}; wb_data = {32'h1234, 32'h0};
    #1;
    chk("x0_ready", wb_ready, 2'b10);
    step();
    wb_valid = 0;
    chk("x0_wr_en", wr_en, 0);
    chk("x0_err", sb_err, 0);

    // 3: both requesters valid, pointer back at 0
    for (int r = 10; r <= 14; r++) issue(5'(r));
    wb_valid = 2'b11;
    foreach (av[i]) begin
      wb_addr = {av[i].a_lsu, av[i].a_alu};
      wb_data = {27'h100, av[i].a_lsu, 27'h200, av[i].a_alu};
      #1;
      chk($sformatf("arb_ready%0d", i), wb_ready, av[i].exp_rdy);
      step();
      chk($sformatf("arb_wr_en%0d", i), wr_en, 1);
      chk($sformatf("arb_wr_addr%0d", i), wr_addr, av[i].exp_addr);
      chk($sformatf("arb_wr_data%0d", i), wr_data,
          {(av[i].exp_rdy[1] ? 27'h100 : 27'h200), av[i].exp_addr});
    end
    wb_valid = 0;
    chk("arb_err", sb_err, 0);

    // 5: write-back to a non-busy register is sticky
    wb_valid = 2'b10; wb_addr = {5'd7, 5'd0};
    #1;
    chk("err_ready", wb_ready, 2'b10);
    step();
    wb_valid = 0;
    chk("err_set", sb_err, 1);
    step();
    step();
    chk("err_sticky", sb_err, 1);

    // 6: reset right after a handshake drops the pending write and the pointer
    issue(9);
    wb_valid = 2'b01; wb_addr = {5'd0, 5'd9}; wb_data = {32'h0, 32'hCAFE0009};
    #1;
    chk("r9_ready", wb_ready, 2'b01);
    step();
    wb_valid = 0; rst = 1;
    #1;
    chk("rst_drop_wr", wr_en, 0);
    step();
    rst = 0;
    #1;
    chk("rst_err_clr", sb_err, 0);
    chk("rst_wr_en_after", wr_en, 0);
    iss_valid = 1; rs1 = 9; rs2 = 0; rd = 14; iss_we = 1;
    #1;
    chk("rst_busy_clr", stall, 0);
    iss_valid = 0; iss_we = 0;
    wb_valid = 2'b11;
    #1;
    chk("rst_ptr0", wb_ready, 2'b01);
    wb_valid = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
